disp_arbiter: RTL

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/disp_arbiter.sv
// Display arbiter: shows base game digits, or a granted player message held
// for HOLD_CYC cycles with optional blink. Round-robin between two sources.
module disp_arbiter #(
  parameter int unsigned HOLD_CYC  = 100,
  parameter int unsigned BLINK_CYC = 25,
  parameter logic [7:0]  BLANK     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  base0,
  input  logic [7:0]  base1,
  input  logic [7:0]  base2,
  input  logic [7:0]  base3,
  input  logic        req_a,
  input  logic [31:0] msg_a,
  input  logic        req_b,
  input  logic [31:0] msg_b,
  output logic [7:0]  disp0,
  output logic [7:0]  disp1,
  output logic [7:0]  disp2,
  output logic [7:0]  disp3,
  output logic        ack_a,
  output logic        ack_b,
  output logic        busy,
  output logic [1:0]  src
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned MSG_W = 32;
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LD = (BLINK_CYC > 0) ? CNT_W'(BLINK_CYC - 1) : '0;
  localparam bit               BLINK_EN = (BLINK_CYC != 0);
  localparam logic [1:0] SRC_BASE = 2'b00;
  localparam logic [1:0] SRC_A    = 2'b01;
  localparam logic [1:0] SRC_B    = 2'b10;

  typedef enum logic {IDLE, SHOW} state_e;

  state_e             state_q, state_d;
  logic               pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [MSG_W-1:0]   msg_a_q, msg_a_d, msg_b_q, msg_b_d;
  logic [MSG_W-1:0]   show_q, show_d;
  logic [CNT_W-1:0]   hold_q, hold_d, blink_q, blink_d;
  logic               vis_q, vis_d;
  logic               last_b_q, last_b_d;
  logic               ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic               busy_q, busy_d;
  logic [1:0]         src_q, src_d;
  logic [MSG_W-1:0]   disp_q, disp_d;
  logic               grant_a, grant_b, slot_free;
  logic [MSG_W-1:0]   base_w;

  assign base_w = {base3, base2, base1, base0};

  // State and datapath registers; reset blanks the display and favours A on first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      msg_a_q  <= '0;
      msg_b_q  <= '0;
      show_q   <= '0;
      hold_q   <= '0;
      blink_q  <= '0;
      vis_q    <= 1'b1;
      last_b_q <= 1'b1;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      src_q    <= SRC_BASE;
      disp_q   <= {4{BLANK}};
    end else begin
      state_q  <= state_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      msg_a_q  <= msg_a_d;
      msg_b_q  <= msg_b_d;
      show_q   <= show_d;
      hold_q   <= hold_d;
      blink_q  <= blink_d;
      vis_q    <= vis_d;
      last_b_q <= last_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
      src_q    <= src_d;
      disp_q   <= disp_d;
    end
  end

  // Next-state: clr aborts everything, otherwise grant / hold-down / idle, then capture requests
  always_comb begin
    state_d  = state_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    msg_a_d  = msg_a_q;
    msg_b_d  = msg_b_q;
    show_d   = show_q;
    hold_d   = hold_q;
    blink_d  = blink_q;
    vis_d    = vis_q;
    last_b_d = last_b_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    busy_d   = busy_q;
    src_d    = src_q;
    disp_d   = disp_q;
    grant_a  = 1'b0;
    grant_b  = 1'b0;

    slot_free = (state_q == IDLE) || (hold_q == '0);
    if (slot_free && (pend_a_q || pend_b_q)) begin
      // On a tie, A wins only if B was granted last
      grant_a = (pend_a_q && pend_b_q) ? last_b_q : pend_a_q;
      grant_b = !grant_a;
    end

    if (clr) begin
      state_d  = IDLE;
      pend_a_d = 1'b0;
      pend_b_d = 1'b0;
      hold_d   = '0;
      blink_d  = '0;
      vis_d    = 1'b1;
      busy_d   = 1'b0;
      src_d    = SRC_BASE;
      disp_d   = base_w;
    end else begin
      if (grant_a || grant_b) begin
        state_d  = SHOW;
        show_d   = grant_a ? msg_a_q : msg_b_q;
        hold_d   = HOLD_LD;
        blink_d  = BLINK_LD;
        vis_d    = 1'b1;
        last_b_d = grant_b;
        ack_a_d  = grant_a;
        ack_b_d  = grant_b;
        busy_d   = 1'b1;
        src_d    = grant_a ? SRC_A : SRC_B;
        if (grant_a) pend_a_d = 1'b0;
        if (grant_b) pend_b_d = 1'b0;
        disp_d   = show_d;
      end else if (state_q == SHOW && hold_q != '0) begin
        hold_d = hold_q - CNT_W'(1);
        if (BLINK_EN) begin
          if (blink_q == '0) begin
            vis_d   = !vis_q;
            blink_d = BLINK_LD;
          end else begin
            blink_d = blink_q - CNT_W'(1);
          end
        end
        disp_d = vis_d ? show_q : {4{BLANK}};
      end else begin
        state_d = IDLE;
        hold_d  = '0;
        busy_d  = 1'b0;
        src_d   = SRC_BASE;
        disp_d  = base_w;
      end
      // Requests in the grant cycle re-arm the slot; latest data wins
      if (req_a) begin
        pend_a_d = 1'b1;
        msg_a_d  = msg_a;
      end
      if (req_b) begin
        pend_b_d = 1'b1;
        msg_b_d  = msg_b;
      end
    end
  end

  assign disp0 = disp_q[7:0];
  assign disp1 = disp_q[15:8];
  assign disp2 = disp_q[23:16];
  assign disp3 = disp_q[31:24];
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign busy  = busy_q;
  assign src   = src_q;

endmodule
